// File: rtl/mc_control_unit_pkg.sv
// Shared types and constants for the multi-cycle control unit: state encoding,
// opcode map, ALU function codes, PC operations and the opcode decoder.
package mc_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_WRITEBACK,
    ST_BRANCH,
    ST_HALT,
    ST_FAULT
  } state_e;

  typedef enum logic [1:0] {
    CLS_ALU,
    CLS_BRANCH,
    CLS_HALT
  } op_class_e;

  localparam logic [3:0] OP_MOVB = 4'b0000;
  localparam logic [3:0] OP_MOVA = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_ADDI = 4'b0011;
  localparam logic [3:0] OP_SUB  = 4'b0101;
  localparam logic [3:0] OP_ANDI = 4'b0110;
  localparam logic [3:0] OP_AND  = 4'b0111;
  localparam logic [3:0] OP_OR   = 4'b1001;
  localparam logic [3:0] OP_JMP  = 4'b1010;
  localparam logic [3:0] OP_JZ   = 4'b1011;
  localparam logic [3:0] OP_HALT = 4'b1111;

  localparam logic [2:0] ALU_PASS = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;
  localparam logic [2:0] ALU_AND  = 3'b011;
  localparam logic [2:0] ALU_OR   = 3'b100;

  localparam logic [1:0] PC_HOLD = 2'b00;
  localparam logic [1:0] PC_INC  = 2'b01;
  localparam logic [1:0] PC_LOAD = 2'b10;

  typedef struct packed {
    logic      legal;
    op_class_e cls;
    logic [2:0] alu_func;
    logic      src_imm;
  } op_dec_t;

  // Maps an opcode to its class and ALU controls; unknown opcodes are flagged illegal.
  function automatic op_dec_t decode_op(input logic [3:0] op);
    op_dec_t d;
    d.legal    = 1'b1;
    d.cls      = CLS_ALU;
    d.alu_func = ALU_PASS;
    d.src_imm  = 1'b0;
    case (op)
      OP_MOVB: ;
      OP_MOVA: d.src_imm = 1'b1;
      OP_ADD:  d.alu_func = ALU_ADD;
      OP_ADDI: begin d.alu_func = ALU_ADD; d.src_imm = 1'b1; end
      OP_SUB:  begin d.alu_func = ALU_SUB; d.src_imm = 1'b1; end
      OP_ANDI: begin d.alu_func = ALU_AND; d.src_imm = 1'b1; end
      OP_AND:  d.alu_func = ALU_AND;
      OP_OR:   begin d.alu_func = ALU_OR; d.src_imm = 1'b1; end
      OP_JMP, OP_JZ: d.cls = CLS_BRANCH;
      OP_HALT: d.cls = CLS_HALT;
      default: d.legal = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/mc_control_unit_if.sv
// Handshake and control bus between the sequencer (master) and the datapath (slave).
interface mc_control_unit_if #(
  parameter int NUM_REGS = 4,
  parameter int CNT_W    = 16
);
  localparam int RD_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  logic                start;
  logic                ir_valid;
  logic                alu_done;
  logic [3:0]          opcode;
  logic [RD_W-1:0]     rd;
  logic                z_flag;
  logic                fetch_pulse;
  logic                pc_pulse;
  logic [1:0]          pc_ctrl;
  logic                group_pulse;
  logic                alu_src_imm;
  logic [2:0]          alu_func;
  logic [NUM_REGS-1:0] reg_we;
  logic                halted;
  logic                fault;
  logic [CNT_W-1:0]    retired;

  modport master (
    input  start, ir_valid, alu_done, opcode, rd, z_flag,
    output fetch_pulse, pc_pulse, pc_ctrl, group_pulse, alu_src_imm, alu_func,
           reg_we, halted, fault, retired
  );

  modport slave (
    output start, ir_valid, alu_done, opcode, rd, z_flag,
    input  fetch_pulse, pc_pulse, pc_ctrl, group_pulse, alu_src_imm, alu_func,
           reg_we, halted, fault, retired
  );
endinterface

// File: rtl/mc_control_unit_wait_timer.sv
// Cycle counter for handshake waits; expired is high in the TIMEOUT-th cycle after a clear.
module wait_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic run_i,
  output logic expired_o
);
  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] LAST = TW'(TIMEOUT - 1);

  logic [TW-1:0] cnt_q, cnt_d;

  // Clear has priority; the count saturates at the last cycle so expired stays asserted.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)
      cnt_d = '0;
    else if (run_i && (cnt_q != LAST))
      cnt_d = cnt_q + 1'b1;
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign expired_o = (cnt_q == LAST);
endmodule

// File: rtl/mc_control_unit.sv
// Multi-cycle instruction sequencer: fetch, decode, execute and write-back with
// HALT, sticky FAULT, handshake timeouts and a wrapping retired-instruction counter.
module mc_control_unit
  import mc_ctrl_pkg::*;
#(
  parameter int NUM_REGS = 4,
  parameter int TIMEOUT  = 16,
  parameter int CNT_W    = 16
) (
  input logic               clk,
  input logic               rst,
  mc_control_unit_if.master bus
);
  localparam int RD_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  state_e state_q, state_d;

  logic [3:0]      op_q;
  logic [RD_W-1:0] rd_q;
  logic            z_q;
  logic [3:0]      op_eff;
  logic [RD_W-1:0] rd_eff;
  logic            z_eff;
  op_dec_t         dec;
  logic            enter, taken, retire;
  logic            tmr_clear, tmr_run, tmr_expired;

  logic                fetch_q, fetch_d;
  logic                pcp_q, pcp_d;
  logic [1:0]          pcc_q, pcc_d;
  logic                grp_q, grp_d;
  logic                imm_q, imm_d;
  logic [2:0]          func_q, func_d;
  logic [NUM_REGS-1:0] we_q, we_d;
  logic                halt_q, halt_d;
  logic                fault_q, fault_d;
  logic [CNT_W-1:0]    ret_q, ret_d;

  // While in DECODE the IR fields are live on the bus; afterwards use the captured copy.
  assign op_eff = (state_q == ST_DECODE) ? bus.opcode : op_q;
  assign rd_eff = (state_q == ST_DECODE) ? bus.rd     : rd_q;
  assign z_eff  = (state_q == ST_DECODE) ? bus.z_flag : z_q;
  assign dec    = decode_op(op_eff);
  assign taken  = (op_eff == OP_JMP) || ((op_eff == OP_JZ) && z_eff);

  assign enter     = (state_d != state_q);
  assign tmr_clear = enter && ((state_d == ST_FETCH) || (state_d == ST_EXEC));
  assign tmr_run   = (state_q == ST_FETCH) || (state_q == ST_EXEC);

  wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (tmr_clear),
    .run_i     (tmr_run),
    .expired_o (tmr_expired)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; the handshake is checked before the timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_HALT: if (bus.start) state_d = ST_FETCH;
      ST_FETCH: begin
        if (bus.ir_valid)      state_d = ST_DECODE;
        else if (tmr_expired)  state_d = ST_FAULT;
      end
      ST_DECODE: begin
        if (!dec.legal) state_d = ST_FAULT;
        else begin
          case (dec.cls)
            CLS_ALU:    state_d = ST_EXEC;
            CLS_BRANCH: state_d = ST_BRANCH;
            CLS_HALT:   state_d = ST_HALT;
            default:    state_d = ST_FAULT;
          endcase
        end
      end
      ST_EXEC: begin
        if (bus.alu_done)      state_d = ST_WRITEBACK;
        else if (tmr_expired)  state_d = ST_FAULT;
      end
      ST_WRITEBACK, ST_BRANCH: state_d = ST_FETCH;
      ST_FAULT: state_d = ST_FAULT;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs, pulses only on state entry.
  always_comb begin
    fetch_d = enter && (state_d == ST_FETCH);
    grp_d   = enter && (state_d == ST_EXEC);
    pcp_d   = fetch_d || (enter && (state_d == ST_BRANCH) && taken);
    pcc_d   = PC_HOLD;
    if (fetch_d)    pcc_d = PC_INC;
    else if (pcp_d) pcc_d = PC_LOAD;
    func_d  = (state_d == ST_EXEC) ? dec.alu_func : ALU_PASS;
    imm_d   = (state_d == ST_EXEC) ? dec.src_imm  : 1'b0;
    we_d    = (state_d == ST_WRITEBACK) ? (NUM_REGS'(1) << rd_eff) : '0;
    halt_d  = (state_d == ST_HALT);
    fault_d = (state_d == ST_FAULT);
    retire  = (state_q == ST_WRITEBACK) || (state_q == ST_BRANCH) ||
              ((state_q == ST_DECODE) && (state_d == ST_HALT));
    ret_d   = ret_q + CNT_W'(retire);
  end

  // Registered outputs and retired counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_q <= 1'b0;
      pcp_q   <= 1'b0;
      pcc_q   <= PC_HOLD;
      grp_q   <= 1'b0;
      imm_q   <= 1'b0;
      func_q  <= ALU_PASS;
      we_q    <= '0;
      halt_q  <= 1'b0;
      fault_q <= 1'b0;
      ret_q   <= '0;
    end else begin
      fetch_q <= fetch_d;
      pcp_q   <= pcp_d;
      pcc_q   <= pcc_d;
      grp_q   <= grp_d;
      imm_q   <= imm_d;
      func_q  <= func_d;
      we_q    <= we_d;
      halt_q  <= halt_d;
      fault_q <= fault_d;
      ret_q   <= ret_d;
    end
  end

  // Instruction fields are captured once, at the end of DECODE.
  always_ff @(posedge clk) begin
    if (state_q == ST_DECODE) begin
      op_q <= bus.opcode;
      rd_q <= bus.rd;
      z_q  <= bus.z_flag;
    end
  end

  assign bus.fetch_pulse = fetch_q;
  assign bus.pc_pulse    = pcp_q;
  assign bus.pc_ctrl     = pcc_q;
  assign bus.group_pulse = grp_q;
  assign bus.alu_src_imm = imm_q;
  assign bus.alu_func    = func_q;
  assign bus.reg_we      = we_q;
  assign bus.halted      = halt_q;
  assign bus.fault       = fault_q;
  assign bus.retired     = ret_q;
endmodule
